ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. It consumes the decoded operation from the ID/EX register: aluop, alusel, two 32-bit operands, destination and write-enable.
- Logic, shift and HI/LO-move results are produced combinationally in the same cycle.
- DIV/DIVU run on an embedded iterative radix-2 divider. A stall request holds the pipeline while the divider is busy.
- Outputs feed the EX/MEM register and the ex_* forwarding inputs of the decode stage.

Parameters:
- DATA_W, 32, operand/result width (fixed by ISA; not overridden)
- CNT_W, 6, divider iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- aluop_i  in  8  operation code
- alusel_i  in  3  result class select
- reg1_i  in  32  operand 1 (rs value, or shift amount for SLL/SRL/SRA)
- reg2_i  in  32  operand 2 (rt value or immediate)
- wd_i  in  5  destination register
- wreg_i  in  1  destination write enable
- hi_i  in  32  architectural HI
- lo_i  in  32  architectural LO
- mem_whilo_i  in  1  MEM stage writes HI/LO
- mem_hi_i  in  32  MEM-stage HI value (forwarding)
- mem_lo_i  in  32  MEM-stage LO value (forwarding)
- flush_i  in  1  annul in-flight instruction
- wdata_o  out  32  GPR result
- wd_o  out  5  destination
- wreg_o  out  1  GPR write enable
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI result
- lo_o  out  32  LO result
- stallreq_o  out  1  hold IF/ID/EX request

Behaviour:
- Reset: rst is synchronous, active-high. All state registers are cleared at the next edge: FSM to IDLE, counter 0, dividend/divisor/partial-remainder 0.
  - While rst=1, all outputs are forced to 0.
- Logic class (alusel=RES_LOGIC):
  - OR/AND/XOR/NOR: bitwise operation on reg1_i and reg2_i.
- Shift class (alusel=RES_SHIFT):
  - SLL/SLLV: reg2 << reg1[4:0].
  - SRL/SRLV: logical right shift.
  - SRA/SRAV: arithmetic right shift, sign-filled from reg2[31]. Shift amount 0 passes reg2 unchanged.
- Move class (alusel=RES_MOVE):
  - MFHI/MFLO return HI or LO.
  - When mem_whilo_i=1, mem_hi_i/mem_lo_i take priority over hi_i/lo_i.
- NOP or unknown class: wdata_o=0.
- wd_o=wd_i and wreg_o=wreg_i in every cycle; both are forced 0 for DIV/DIVU.
- Non-divide operations: whilo_o=0 and stallreq_o=0.
- Divider FSM, states IDLE, ZERO, BUSY, DONE:
  - IDLE:
    - If aluop is DIV/DIVU and flush_i=0: stallreq_o=1.
    - If reg2_i==0, go to ZERO.
    - Otherwise latch |reg1|, |reg2| (signed DIV) or raw values (DIVU), clear partial remainder and counter, go to BUSY.
  - ZERO: stallreq_o=1. Quotient=0, remainder=0; go to DONE.
  - BUSY: stallreq_o=1. Each cycle:
    - Shift {rem,quot} left 1.
    - Trial-subtract divisor from rem (33-bit). If the result is non-negative, keep the difference and set quot[0]=1.
    - Counter +1. After the 32nd iteration (counter==31 at the edge), go to DONE.
  - DONE: stallreq_o=0, whilo_o=1.
    - lo_o=quotient, hi_o=remainder.
    - DIV sign fix: quotient negated if signs of the operands differ; remainder takes the dividend sign.
    - Next state IDLE unconditionally, because the pipeline advances at this edge.
- Latency:
  - Nonzero divisor: stallreq_o high for 33 cycles (IDLE + 32 BUSY); result valid in cycle 34.
  - Zero divisor: stallreq_o high for 2 cycles; result in cycle 3.
- Boundary cases:
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
  - flush_i=1 in any state: go to IDLE next edge; stallreq_o=0 and whilo_o=0 that cycle.
  - rst during BUSY: abort; no HI/LO write.
- Upstream must hold the aluop/reg1/reg2 inputs stable while stallreq_o=1. Operands are latched at IDLE, so later changes are ignored.

Decomposition:
- Shared defines file carries the aluop codes, the alusel codes (RES_LOGIC/SHIFT/MOVE/NOP) and the bus widths.
- Divider FSM state encodings live in that same file.
- One sub-module: div_unit, holding the FSM, counter and datapath.
  - Inputs: start, signed, a, b, annul.
  - Outputs: busy, done, q, r.
- ex_stage holds the combinational ALU and output muxing.

Test Plan:
- ORI-style: alusel LOGIC, OR, reg1=0x0000F0F0, reg2=0x00000F0F -> wdata_o=0x0000FFFF, wreg_o=1, stallreq_o=0, same cycle.
- SRA: reg1=4, reg2=0x80000010 -> wdata_o=0xF8000001; SRL same operands -> 0x08000001.
- MFHI with mem_whilo_i=1, mem_hi_i=0x12345678, hi_i=0xDEADBEEF -> wdata_o=0x12345678.
- DIV signed: reg1=-7 (0xFFFFFFF9), reg2=2 -> stallreq_o high 33 cycles, then one cycle whilo_o=1, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIV by zero: reg2=0 -> stall 2 cycles, then whilo_o=1, hi_o=lo_o=0.
- Abort: start DIVU, assert flush_i at BUSY cycle 10 -> next cycle stallreq_o=0, whilo_o never 1. Repeat the run with rst at cycle 10 -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared opcodes, result-class selects, bus widths and divider state encodings
// for the MIPS32 execute stage.
package ex_stage_pkg;

    localparam int XLEN     = 32;
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;
    localparam int REGADR_W = 5;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [ALUSEL_W-1:0] RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] RES_MOVE  = 3'b011;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_ZERO = 2'b01;
    localparam logic [1:0] DIV_BUSY = 2'b10;
    localparam logic [1:0] DIV_DONE = 2'b11;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand bus in, EX/MEM result bus out. The stage itself uses the
// slave modport; whoever drives the decoded instruction uses master.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [ALUOP_W-1:0]  aluop_i;
    logic [ALUSEL_W-1:0] alusel_i;
    logic [XLEN-1:0]     reg1_i;
    logic [XLEN-1:0]     reg2_i;
    logic [REGADR_W-1:0] wd_i;
    logic                wreg_i;
    logic [XLEN-1:0]     hi_i;
    logic [XLEN-1:0]     lo_i;
    logic                mem_whilo_i;
    logic [XLEN-1:0]     mem_hi_i;
    logic [XLEN-1:0]     mem_lo_i;
    logic                flush_i;
    logic [XLEN-1:0]     wdata_o;
    logic [REGADR_W-1:0] wd_o;
    logic                wreg_o;
    logic                whilo_o;
    logic [XLEN-1:0]     hi_o;
    logic [XLEN-1:0]     lo_o;
    logic                stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
               mem_whilo_i, mem_hi_i, mem_lo_i, flush_i,
        input  wdata_o, wd_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
               mem_whilo_i, mem_hi_i, mem_lo_i, flush_i,
        output wdata_o, wd_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signs are
// stripped on entry and re-applied combinationally in the DONE state.
module ex_stage_div_unit
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              annul_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] q_o,
    output logic [DATA_W-1:0] r_o
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;

    logic              a_neg, b_neg;
    logic [DATA_W:0]   rem_sh;

    assign a_neg  = signed_i & a_i[DATA_W-1];
    assign b_neg  = signed_i & b_i[DATA_W-1];
    assign rem_sh = {rem_q, quot_q[DATA_W-1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    if (b_i == '0) begin
                        state_d = DIV_ZERO;
                    end else begin
                        quot_d    = a_neg ? -a_i : a_i;
                        divisor_d = b_neg ? -b_i : b_i;
                        rem_d     = '0;
                        cnt_d     = '0;
                        q_neg_d   = a_neg ^ b_neg;
                        r_neg_d   = a_neg;
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_ZERO: begin
                quot_d  = '0;
                rem_d   = '0;
                q_neg_d = 1'b0;
                r_neg_d = 1'b0;
                state_d = DIV_DONE;
            end
            DIV_BUSY: begin
                // rem_sh < 2*divisor, so the low DATA_W bits of the difference are exact
                if (rem_sh >= {1'b0, divisor_q}) begin
                    rem_d  = rem_sh[DATA_W-1:0] - divisor_q;
                    quot_d = {quot_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[DATA_W-1:0];
                    quot_d = {quot_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1))
                    state_d = DIV_DONE;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (annul_i)
            state_d = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
        end
    end

    assign busy_o = ~annul_i & ((state_q == DIV_IDLE & start_i) |
                                state_q == DIV_ZERO | state_q == DIV_BUSY);
    assign done_o = ~annul_i & (state_q == DIV_DONE);
    assign q_o    = q_neg_q ? -quot_q : quot_q;
    assign r_o    = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: same-cycle logic/shift/move results plus a
// multi-cycle DIV/DIVU that stalls the front of the pipeline.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    logic              is_div;
    logic [DATA_W-1:0] logic_res, shift_res, move_res, result;
    logic [DATA_W-1:0] hi_fwd, lo_fwd;
    logic [4:0]        shamt;
    logic              div_busy, div_done;
    logic [DATA_W-1:0] div_q, div_r;

    assign is_div = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
    assign shamt  = bus.reg1_i[4:0];
    assign hi_fwd = bus.mem_whilo_i ? bus.mem_hi_i : bus.hi_i;
    assign lo_fwd = bus.mem_whilo_i ? bus.mem_lo_i : bus.lo_i;

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        move_res  = '0;
        case (bus.aluop_i)
            EXE_OR_OP:   logic_res = bus.reg1_i | bus.reg2_i;
            EXE_AND_OP:  logic_res = bus.reg1_i & bus.reg2_i;
            EXE_XOR_OP:  logic_res = bus.reg1_i ^ bus.reg2_i;
            EXE_NOR_OP:  logic_res = ~(bus.reg1_i | bus.reg2_i);
            default:     logic_res = '0;
        endcase
        case (bus.aluop_i)
            EXE_SLL_OP:  shift_res = bus.reg2_i << shamt;
            EXE_SRL_OP:  shift_res = bus.reg2_i >> shamt;
            EXE_SRA_OP:  shift_res = $signed(bus.reg2_i) >>> shamt;
            default:     shift_res = '0;
        endcase
        case (bus.aluop_i)
            EXE_MFHI_OP: move_res = hi_fwd;
            EXE_MFLO_OP: move_res = lo_fwd;
            default:     move_res = '0;
        endcase
        case (bus.alusel_i)
            RES_LOGIC:   result = logic_res;
            RES_SHIFT:   result = shift_res;
            RES_MOVE:    result = move_res;
            default:     result = '0;
        endcase
    end

    ex_stage_div_unit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_div_unit (
        .clk      (clk),
        .rst      (rst),
        .start_i  (is_div),
        .signed_i (bus.aluop_i == EXE_DIV_OP),
        .a_i      (bus.reg1_i),
        .b_i      (bus.reg2_i),
        .annul_i  (bus.flush_i),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .q_o      (div_q),
        .r_o      (div_r)
    );

    // Reset blanks everything so nothing half-computed leaks into EX/MEM.
    assign bus.wdata_o    = rst ? '0 : result;
    assign bus.wd_o       = (rst | is_div) ? '0 : bus.wd_i;
    assign bus.wreg_o     = ~rst & ~is_div & bus.wreg_i;
    assign bus.whilo_o    = ~rst & div_done;
    assign bus.hi_o       = (rst | ~div_done) ? '0 : div_r;
    assign bus.lo_o       = (rst | ~div_done) ? '0 : div_q;
    assign bus.stallreq_o = ~rst & div_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU classes, HI/LO forwarding, divider
// latency and results, and flush/reset aborts of an in-flight divide.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2);
        @(posedge clk);
        #1;
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        @(negedge clk);
    endtask

    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.aluop_i  = op;
        bus.alusel_i = RES_NOP;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.stallreq_o !== 1'b1) break;
            if (n == 0) check({tag, "_wreg_during_div"}, 32'(bus.wreg_o), 32'd0);
            n++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        check({tag, "_whilo"}, 32'(bus.whilo_o), 32'd1);
        check({tag, "_lo"}, bus.lo_o, exp_lo);
        check({tag, "_hi"}, bus.hi_o, exp_hi);
        $display("div %s a=0x%08h b=0x%08h stall=%0d lo=0x%08h hi=0x%08h",
                 tag, a, b, n, bus.lo_o, bus.hi_o);
        @(posedge clk);
        #1;
        bus.aluop_i = EXE_NOP_OP;
        @(negedge clk);
        check({tag, "_whilo_after"}, 32'(bus.whilo_o), 32'd0);
    endtask

    initial begin
        int seen;
        rst             = 1'b1;
        bus.aluop_i     = EXE_OR_OP;
        bus.alusel_i    = RES_LOGIC;
        bus.reg1_i      = 32'h0000_F0F0;
        bus.reg2_i      = 32'h0000_0F0F;
        bus.wd_i        = 5'd5;
        bus.wreg_i      = 1'b1;
        bus.hi_i        = 32'hDEAD_BEEF;
        bus.lo_i        = 32'hCAFE_F00D;
        bus.mem_whilo_i = 1'b0;
        bus.mem_hi_i    = 32'h1234_5678;
        bus.mem_lo_i    = 32'h8765_4321;
        bus.flush_i     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wdata", bus.wdata_o, 32'd0);
        check("rst_wreg", 32'(bus.wreg_o), 32'd0);
        check("rst_wd", 32'(bus.wd_o), 32'd0);
        check("rst_stall", 32'(bus.stallreq_o), 32'd0);
        $display("reset outputs wdata=0x%08h wreg=%0b stall=%0b", bus.wdata_o, bus.wreg_o, bus.stallreq_o);

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("or_wdata", bus.wdata_o, 32'h0000_FFFF);
        check("or_wreg", 32'(bus.wreg_o), 32'd1);
        check("or_wd", 32'(bus.wd_o), 32'd5);
        check("or_stall", 32'(bus.stallreq_o), 32'd0);
        check("or_whilo", 32'(bus.whilo_o), 32'd0);
        $display("or wdata=0x%08h", bus.wdata_o);

        step(EXE_AND_OP, RES_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F);
        check("and_wdata", bus.wdata_o, 32'h0000_0000);
        step(EXE_XOR_OP, RES_LOGIC, 32'hFF00_F0F0, 32'h0F0F_0F0F);
        check("xor_wdata", bus.wdata_o, 32'hF00F_FFFF);
        step(EXE_NOR_OP, RES_LOGIC, 32'h0000_F0F0, 32'h0000_0F0F);
        check("nor_wdata", bus.wdata_o, 32'hFFFF_0000);
        step(EXE_SRA_OP, RES_SHIFT, 32'd4, 32'h8000_0010);
        check("sra_wdata", bus.wdata_o, 32'hF800_0001);
        step(EXE_SRL_OP, RES_SHIFT, 32'd4, 32'h8000_0010);
        check("srl_wdata", bus.wdata_o, 32'h0800_0001);
        step(EXE_SLL_OP, RES_SHIFT, 32'h0000_0024, 32'h8000_0010);
        check("sll_wdata", bus.wdata_o, 32'h0000_0100);
        step(EXE_SRA_OP, RES_SHIFT, 32'd0, 32'h8000_0010);
        check("sra0_wdata", bus.wdata_o, 32'h8000_0010);
        step(EXE_SRA_OP, RES_SHIFT, 32'd31, 32'h8000_0000);
        check("sra31_wdata", bus.wdata_o, 32'hFFFF_FFFF);
        $display("shift checks done wdata=0x%08h", bus.wdata_o);

        bus.mem_whilo_i = 1'b1;
        step(EXE_MFHI_OP, RES_MOVE, 32'd0, 32'd0);
        check("mfhi_fwd", bus.wdata_o, 32'h1234_5678);
        step(EXE_MFLO_OP, RES_MOVE, 32'd0, 32'd0);
        check("mflo_fwd", bus.wdata_o, 32'h8765_4321);
        bus.mem_whilo_i = 1'b0;
        step(EXE_MFHI_OP, RES_MOVE, 32'd0, 32'd0);
        check("mfhi_arch", bus.wdata_o, 32'hDEAD_BEEF);
        step(EXE_OR_OP, RES_NOP, 32'h0000_F0F0, 32'h0000_0F0F);
        check("nop_wdata", bus.wdata_o, 32'd0);
        $display("move/nop checks done wdata=0x%08h", bus.wdata_o);

        run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div("div_min_m1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        run_div("div_zero", EXE_DIV_OP, 32'd55, 32'd0, 2, 32'd0, 32'd0);

        // Flush at BUSY cycle 10
        @(posedge clk);
        #1;
        bus.aluop_i = EXE_DIVU_OP;
        bus.reg1_i  = 32'd100;
        bus.reg2_i  = 32'd7;
        repeat (11) @(negedge clk);
        @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(bus.stallreq_o), 32'd0);
        check("flush_whilo", 32'(bus.whilo_o), 32'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.aluop_i = EXE_NOP_OP;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) seen++;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        $display("flush abort stall=%0b whilo events=%0d", bus.stallreq_o, seen);

        // Reset at BUSY cycle 10
        @(posedge clk);
        #1;
        bus.aluop_i = EXE_DIVU_OP;
        repeat (11) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstdiv_stall", 32'(bus.stallreq_o), 32'd0);
        check("rstdiv_whilo", 32'(bus.whilo_o), 32'd0);
        check("rstdiv_hi", bus.hi_o, 32'd0);
        check("rstdiv_lo", bus.lo_o, 32'd0);
        check("rstdiv_wdata", bus.wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.aluop_i = EXE_NOP_OP;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) seen++;
        end
        check("rstdiv_no_result", 32'(seen), 32'd0);
        $display("reset abort whilo events=%0d", seen);
        // A fresh divide-by-zero only takes 2 stall cycles if the FSM is back in IDLE.
        run_div("post_rst_zero", EXE_DIVU_OP, 32'd9, 32'd0, 2, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
